// File: rtl/booth_pkg.sv
// ----------------------------------------------------------------------------
// booth_pkg : shared types and constants for the Booth multiplier arbiter
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package booth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int TIMEOUT_DEF = 64;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_mult_arbiter_if.sv
// ----------------------------------------------------------------------------
// booth_mult_arbiter_if : requester, response and multiplier-side signals
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface booth_mult_arbiter_if
  import booth_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = id_width(NREQ)
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [2*W-1:0]    rsp_prod;
  logic              rsp_err;
  logic              mul_valid;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic              mul_done;
  logic [2*W-1:0]    mul_prod;

  // The arbiter serves requests, so it takes the slave view.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_done, mul_prod,
    output req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err, mul_valid, mul_a, mul_b
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_done, mul_prod,
    input  req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err, mul_valid, mul_a, mul_b
  );

endinterface

`default_nettype wire

// File: rtl/booth_mult_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, first request at/after pointer
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import booth_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [IDW-1:0]  win_o,
  output logic            any_o
);

  int idx;

  // Scan from the farthest slot back to the pointer so the nearest one wins.
  always_comb begin
    any_o = 1'b0;
    win_o = '0;
    idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_i[IDW'(idx)]) begin
        any_o = 1'b1;
        win_o = IDW'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/multiplicacion.sv
// ----------------------------------------------------------------------------
// multiplicacion : sequential radix-2 signed Booth multiplier, done held high
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module multiplicacion #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           done_o,
  output logic [2*W-1:0] prod_o
);

  localparam int CW = $clog2(W + 1);

  // One guard bit on the upper half keeps -2^(W-1) * -2^(W-1) from overflowing.
  logic [2*W+1:0] acc_q;
  logic [W:0]     a_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic           done_q;
  logic [W:0]     up_d;

  always_comb begin
    up_d = acc_q[2*W+1:W+1];
    case (acc_q[1:0])
      2'b01:   up_d = up_d + a_q;
      2'b10:   up_d = up_d - a_q;
      default: up_d = acc_q[2*W+1:W+1];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      a_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      acc_q  <= {{(W+1){1'b0}}, b_i, 1'b0};
      a_q    <= {a_i[W-1], a_i};
      cnt_q  <= '0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      acc_q <= {up_d[W], up_d, acc_q[W:1]};
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CW'(W - 1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign done_o = done_q;
  assign prod_o = acc_q[2*W:1];

endmodule

`default_nettype wire

// File: rtl/booth_mult_arbiter.sv
// ----------------------------------------------------------------------------
// booth_mult_arbiter : round-robin sharing of one Booth multiplier with watchdog
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module booth_mult_arbiter
  import booth_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  booth_mult_arbiter_if.slave   bus
);

  localparam int IDW = id_width(NREQ);
  localparam int TW  = $clog2(TIMEOUT + 1);

  arb_state_t     state_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  logic [IDW-1:0] id_q;
  logic [W-1:0]   mul_a_q;
  logic [W-1:0]   mul_b_q;
  logic           mul_valid_q;
  logic [TW-1:0]  timer_q;
  logic           done_q;
  logic           rsp_valid_q;
  logic [2*W-1:0] rsp_prod_q;
  logic           rsp_err_q;

  logic [IDW-1:0] win;
  logic           any;
  logic           done_rise;
  logic [W-1:0]   a_arr [NREQ];
  logic [W-1:0]   b_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign a_arr[i] = bus.req_a[i*W +: W];
    assign b_arr[i] = bus.req_b[i*W +: W];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .win_o (win),
    .any_o (any)
  );

  assign ptr_d     = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
  // done_q resets high so a done level already present is never seen as an edge.
  assign done_rise = bus.mul_done & ~done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_valid_q <= 1'b0;
      timer_q     <= '0;
      done_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_prod_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      done_q <= bus.mul_done;
      case (state_q)
        IDLE: begin
          if (any) begin
            mul_a_q     <= a_arr[win];
            mul_b_q     <= b_arr[win];
            id_q        <= win;
            ptr_q       <= ptr_d;
            mul_valid_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          mul_valid_q <= 1'b0;
          timer_q     <= '0;
          state_q     <= WAIT;
        end
        WAIT: begin
          if (done_rise) begin
            rsp_prod_q  <= bus.mul_prod;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            rsp_prod_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_prod_q  <= '0;
            rsp_err_q   <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Accept is combinational so the pulse coincides with the operand latch.
  assign bus.req_ready = (state_q == IDLE && any) ? (NREQ'(1) << win) : '0;
  assign bus.mul_valid = mul_valid_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_prod  = rsp_prod_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_booth_mult_arbiter.sv
// ----------------------------------------------------------------------------
// tb_booth_mult_arbiter : scoreboard bench for the shared Booth multiplier
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_booth_mult_arbiter;

  localparam int NREQ    = 4;
  localparam int W       = 8;
  localparam int TIMEOUT = 64;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] prod;
    logic        err;
  } rsp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic mul_done_real;
  int   stub  = 0;     // 0: real done, 1: done stuck low, 2: done stuck high
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   mv_count = 0;
  logic prev_mv = 1'b0;

  rsp_t sbq[$];
  int   gq[$];

  booth_mult_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  booth_mult_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  multiplicacion #(.W(W)) u_mul (
    .clk     (clk),
    .rst     (~rst_n),
    .start_i (bus.mul_valid),
    .a_i     (bus.mul_a),
    .b_i     (bus.mul_b),
    .done_o  (mul_done_real),
    .prod_o  (bus.mul_prod)
  );

  assign bus.mul_done = (stub == 0) ? mul_done_real : (stub == 1) ? 1'b0 : 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Grant monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mul_valid) begin
        mv_count++;
        chk("mul_valid_pulse", {31'd0, prev_mv}, 32'd0);
      end
      prev_mv = bus.mul_valid;
      if (bus.req_ready != '0) begin
        if (gq.size() == 0) chk("unexpected_grant", {28'd0, bus.req_ready}, 32'd0);
        else chk("grant", {28'd0, bus.req_ready}, 32'd1 << gq.pop_front());
      end
    end else begin
      prev_mv = 1'b0;
    end
  end

  // Response monitor: compares every cycle rsp_valid is high, pops on transfer
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        chk("rsp_id",   {30'd0, bus.rsp_id},   {30'd0, sbq[0].id});
        chk("rsp_prod", {16'd0, bus.rsp_prod}, {16'd0, sbq[0].prod});
        chk("rsp_err",  {31'd0, bus.rsp_err},  {31'd0, sbq[0].err});
        if (bus.rsp_ready) void'(sbq.pop_front());
      end
    end
  end

  task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] prod, input logic err, input bit exp_rsp);
    bit got;
    rsp_t e;
    gq.push_back(id);
    if (exp_rsp) begin
      e.id = 2'(id); e.prod = prod; e.err = err;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    bus.req_a[id*W +: W] = a;
    bus.req_b[id*W +: W] = b;
    bus.req_valid[id]    = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (bus.req_ready[id]) got = 1'b1;
    end
    if (!got) chk("grant_wait", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk);
      if (sbq.size() == 0) done = 1'b1;
    end
    if (!done) chk("drain_wait", 32'd0, 32'd1);
  endtask

  task automatic wait_neg(input string nm, input bit want_mv);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (want_mv ? bus.mul_valid : bus.rsp_valid) got = 1'b1;
    end
    if (!got) chk(nm, 32'd0, 32'd1);
  endtask

  initial begin
    int g, t0, mv0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {28'd0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_mul_valid", {31'd0, bus.mul_valid}, 32'd0);
    chk("rst_outputs",   {bus.rsp_prod, bus.mul_a, bus.mul_b}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Four continuous requesters: grants 0,1,2,3 then wrap to 0
    for (int i = 0; i < 5; i++) begin
      rsp_t e;
      gq.push_back(i % 4);
      e.id = 2'(i % 4); e.prod = 16'(((i % 4) + 1) * 5); e.err = 1'b0;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i*W +: W] = 8'(i + 1);
      bus.req_b[i*W +: W] = 8'd5;
    end
    bus.req_valid = 4'hF;
    g = 0;
    for (int k = 0; k < 2000 && g < 5; k++) begin
      @(negedge clk);
      if (bus.req_ready != '0) g++;
    end
    chk("rr_grant_count", g, 5);
    @(posedge clk); #1 bus.req_valid = '0;
    drain();

    // Single request, negative multiplier, exactly one start pulse
    mv0 = mv_count;
    issue(0, 8'd3, 8'hFE, 16'hFFFA, 1'b0, 1'b1);
    drain();
    chk("single_mul_valid_count", mv_count - mv0, 1);

    // Most negative operands with response back-pressure
    bus.rsp_ready = 1'b0;
    issue(1, 8'h80, 8'h80, 16'h4000, 1'b0, 1'b1);
    wait_neg("stall_rsp_wait", 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    drain();

    // Multiplier never completes: watchdog abort after TIMEOUT+1 cycles
    stub = 1;
    issue(2, 8'd1, 8'd1, 16'h0000, 1'b1, 1'b1);
    wait_neg("wd_mv_wait", 1'b1);
    t0 = cyc;
    wait_neg("wd_rsp_wait", 1'b0);
    chk("wd_latency", cyc - t0, TIMEOUT + 1);
    drain();
    stub = 0;
    issue(3, 8'hFD, 8'd4, 16'hFFF4, 1'b0, 1'b1);
    drain();

    // Done stuck high from before the op: no false completion
    stub = 2;
    issue(0, 8'd5, 8'd6, 16'h0000, 1'b1, 1'b1);
    drain();
    stub = 0;
    issue(1, 8'hF9, 8'hF7, 16'h003F, 1'b0, 1'b1);
    drain();

    // Reset asserted during WAIT discards the operation
    stub = 1;
    issue(1, 8'd9, 8'd9, 16'h0000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("wait_mul_a", {24'd0, bus.mul_a}, 32'd9);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("midrst_mul",       {15'd0, bus.mul_valid, bus.mul_a, bus.mul_b}, 32'd0);
    chk("midrst_rsp",       {15'd0, bus.rsp_err, bus.rsp_prod}, 32'd0);
    repeat (3) @(posedge clk);
    stub = 0;
    #1 rst_n = 1'b1;
    issue(2, 8'd7, 8'd7, 16'd49, 1'b0, 1'b1);
    drain();

    repeat (5) @(negedge clk);
    chk("final_rsp_queue",   sbq.size(), 0);
    chk("final_grant_queue", gq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule

`default_nettype wire
